// File: rtl/bcom_conf_host_fsm.sv
// ---------------------------------------------------------------------------
// bcom_conf_host_fsm
//
// Host-side initiator for the RS232 configuration protocol. A write request
// sends CMD_WR followed by NBYTES payload bytes (MSB byte first). A read
// request sends CMD_RD and then collects NBYTES reply bytes (MSB byte first)
// from the receiver. Each transmitted byte is handed to the UART with a
// one-cycle strobe. The FSM waits for the transmitter busy flag to rise and
// then to fall again. If the busy flag never rises, or a reply byte is late,
// the transaction aborts with a timeout pulse.
//
// Ports:
//   clk            system clock, rising edge
//   ic_rst         synchronous reset, active-high
//   ic_start_wr    one-cycle write request (wins over ic_start_rd)
//   ic_start_rd    one-cycle read request
//   id_conf_wdata  write payload, sampled when a write is accepted
//   ic_txbusy      RS232 transmitter busy
//   ic_rxrdy       RS232 receiver byte-valid pulse
//   id_rxdw        RS232 received byte
//   oc_txena       one-cycle transmit strobe
//   od_txdw        byte to transmit, held until the transmitter is done
//   od_conf_rdata  read payload, updated only by a successful read
//   oc_done_wr     one-cycle write-complete pulse
//   oc_done_rd     one-cycle read-complete pulse (od_conf_rdata valid)
//   oc_busy        high whenever the FSM is not idle
//   oc_timeout     one-cycle abort pulse
//   od_sleds       current state code for status LEDs
// ---------------------------------------------------------------------------
module bcom_conf_host_fsm #(
   parameter int         NBYTES        = 4,
   parameter logic [7:0] CMD_WR        = 8'hB1,
   parameter logic [7:0] CMD_RD        = 8'hB2,
   parameter int         TIMEOUT_CYC   = 1000000,
   parameter int         BUSY_WAIT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  ic_rst,
   input  logic                  ic_start_wr,
   input  logic                  ic_start_rd,
   input  logic [8*NBYTES-1:0]   id_conf_wdata,
   input  logic                  ic_txbusy,
   input  logic                  ic_rxrdy,
   input  logic [7:0]            id_rxdw,
   output logic                  oc_txena,
   output logic [7:0]            od_txdw,
   output logic [8*NBYTES-1:0]   od_conf_rdata,
   output logic                  oc_done_wr,
   output logic                  oc_done_rd,
   output logic                  oc_busy,
   output logic                  oc_timeout,
   output logic [2:0]            od_sleds
);

   localparam int DW = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam int BW = $clog2(BUSY_WAIT_CYC + 1);

   // Index of the last data byte (index 0 is the command byte).
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES);
   // Reply count value at which the byte being received is the last one.
   localparam logic [IW-1:0] LAST_RX  = IW'(NBYTES - 1);
   // Counter values seen on the final allowed waiting cycle.
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [BW-1:0] BW_LAST  = BW'(BUSY_WAIT_CYC - 1);

   // Encodings double as the LED codes.
   typedef enum logic [2:0] {
      S_IDLE    = 3'b000,
      S_LOAD    = 3'b001,
      S_TX_STB  = 3'b010,
      S_TX_WH   = 3'b011,
      S_TX_WL   = 3'b100,
      S_RX_WAIT = 3'b101,
      S_DONE    = 3'b110,
      S_ERR     = 3'b111
   } state_t;

   typedef enum logic {
      M_WR = 1'b0,
      M_RD = 1'b1
   } mode_t;

   state_t          state_r;
   state_t          state_nx_s;
   mode_t           mode_r;
   logic [IW-1:0]   idx_r;
   logic [IW-1:0]   rx_cnt_r;
   logic [TW-1:0]   to_cnt_r;
   logic [BW-1:0]   bw_cnt_r;
   logic [DW-1:0]   shadow_r;
   logic [DW-1:0]   rx_sh_r;
   logic [DW-1:0]   rx_next_s;
   logic [7:0]      tx_byte_s;

   logic            oc_txena_r;
   logic [7:0]      od_txdw_r;
   logic [DW-1:0]   od_conf_rdata_r;
   logic            oc_done_wr_r;
   logic            oc_done_rd_r;
   logic            oc_busy_r;
   logic            oc_timeout_r;
   logic [2:0]      od_sleds_r;

   assign oc_txena      = oc_txena_r;
   assign od_txdw       = od_txdw_r;
   assign od_conf_rdata = od_conf_rdata_r;
   assign oc_done_wr    = oc_done_wr_r;
   assign oc_done_rd    = oc_done_rd_r;
   assign oc_busy       = oc_busy_r;
   assign oc_timeout    = oc_timeout_r;
   assign od_sleds      = od_sleds_r;

   // Byte to load next: command first, then the top of the shifting shadow.
   always_comb begin
      tx_byte_s = 8'h00;
      if (idx_r == '0) begin
         if (mode_r == M_WR) begin
            tx_byte_s = CMD_WR;
         end else begin
            tx_byte_s = CMD_RD;
         end
      end else begin
         tx_byte_s = shadow_r[DW-1 -: 8];
      end
   end

   // Receive shift register with the incoming byte appended at the bottom.
   always_comb begin
      rx_next_s = DW'({rx_sh_r, id_rxdw});
   end

   // Next-state decode.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (ic_start_wr || ic_start_rd) begin
               state_nx_s = S_LOAD;
            end else begin
               state_nx_s = S_IDLE;
            end
         end
         S_LOAD: begin
            if (ic_txbusy) begin
               state_nx_s = S_LOAD;
            end else begin
               state_nx_s = S_TX_STB;
            end
         end
         S_TX_STB: begin
            state_nx_s = S_TX_WH;
         end
         S_TX_WH: begin
            // TX_WH may last at most BUSY_WAIT_CYC cycles.
            if (ic_txbusy) begin
               state_nx_s = S_TX_WL;
            end else if (bw_cnt_r == BW_LAST) begin
               state_nx_s = S_ERR;
            end else begin
               state_nx_s = S_TX_WH;
            end
         end
         S_TX_WL: begin
            if (ic_txbusy) begin
               state_nx_s = S_TX_WL;
            end else if (mode_r == M_RD) begin
               state_nx_s = S_RX_WAIT;
            end else if (idx_r == LAST_IDX) begin
               state_nx_s = S_DONE;
            end else begin
               state_nx_s = S_LOAD;
            end
         end
         S_RX_WAIT: begin
            // A reply byte may be at most TIMEOUT_CYC cycles late.
            if (ic_rxrdy) begin
               if (rx_cnt_r == LAST_RX) begin
                  state_nx_s = S_DONE;
               end else begin
                  state_nx_s = S_RX_WAIT;
               end
            end else if (to_cnt_r == TO_LAST) begin
               state_nx_s = S_ERR;
            end else begin
               state_nx_s = S_RX_WAIT;
            end
         end
         S_DONE: begin
            state_nx_s = S_IDLE;
         end
         S_ERR: begin
            state_nx_s = S_IDLE;
         end
         default: begin
            state_nx_s = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (ic_rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Datapath: shadow payload, indices, wait counters and receive capture.
   always_ff @(posedge clk) begin
      if (ic_rst) begin
         mode_r          <= M_WR;
         idx_r           <= '0;
         rx_cnt_r        <= '0;
         to_cnt_r        <= '0;
         bw_cnt_r        <= '0;
         shadow_r        <= '0;
         rx_sh_r         <= '0;
         od_txdw_r       <= 8'h00;
         od_conf_rdata_r <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (ic_start_wr) begin
                  shadow_r <= id_conf_wdata;
                  mode_r   <= M_WR;
                  idx_r    <= '0;
               end else if (ic_start_rd) begin
                  mode_r   <= M_RD;
                  idx_r    <= '0;
               end
            end
            S_LOAD: begin
               od_txdw_r <= tx_byte_s;
            end
            S_TX_STB: begin
               bw_cnt_r <= '0;
            end
            S_TX_WH: begin
               bw_cnt_r <= bw_cnt_r + BW'(1'b1);
            end
            S_TX_WL: begin
               if (!ic_txbusy) begin
                  if (mode_r == M_RD) begin
                     rx_cnt_r <= '0;
                     to_cnt_r <= '0;
                     rx_sh_r  <= '0;
                  end else if (idx_r != LAST_IDX) begin
                     idx_r <= idx_r + IW'(1'b1);
                     // The command byte does not consume payload; every
                     // data byte sent moves the next one to the top.
                     if (idx_r != '0) begin
                        shadow_r <= shadow_r << 4'd8;
                     end
                  end
               end
            end
            S_RX_WAIT: begin
               if (ic_rxrdy) begin
                  rx_sh_r  <= rx_next_s;
                  rx_cnt_r <= rx_cnt_r + IW'(1'b1);
                  to_cnt_r <= '0;
                  if (rx_cnt_r == LAST_RX) begin
                     od_conf_rdata_r <= rx_next_s;
                  end
               end else begin
                  to_cnt_r <= to_cnt_r + TW'(1'b1);
               end
            end
            S_ERR: begin
               rx_sh_r  <= '0;
               rx_cnt_r <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Status and strobe outputs, registered from the next state so that
   // each one is high exactly while the FSM sits in the matching state.
   always_ff @(posedge clk) begin
      if (ic_rst) begin
         oc_txena_r   <= 1'b0;
         oc_done_wr_r <= 1'b0;
         oc_done_rd_r <= 1'b0;
         oc_busy_r    <= 1'b0;
         oc_timeout_r <= 1'b0;
         od_sleds_r   <= 3'b000;
      end else begin
         oc_txena_r   <= (state_nx_s == S_TX_STB);
         oc_done_wr_r <= (state_nx_s == S_DONE) && (mode_r == M_WR);
         oc_done_rd_r <= (state_nx_s == S_DONE) && (mode_r == M_RD);
         oc_busy_r    <= (state_nx_s != S_IDLE);
         oc_timeout_r <= (state_nx_s == S_ERR);
         od_sleds_r   <= state_nx_s;
      end
   end

endmodule

// File: tb/tb_bcom_conf_host_fsm.sv
// ---------------------------------------------------------------------------
// tb_bcom_conf_host_fsm
//
// Directed bench for bcom_conf_host_fsm (NBYTES=4, TIMEOUT_CYC=50,
// BUSY_WAIT_CYC=16). A small UART model answers each transmit strobe with a
// 10-cycle busy window (or never, when stuck) and logs transmitted bytes
// and output pulses; scenario tasks compare against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bcom_conf_host_fsm;

   localparam int NB  = 4;
   localparam int TO  = 50;
   localparam int BWC = 16;

   logic          clk;
   logic          ic_rst;
   logic          ic_start_wr;
   logic          ic_start_rd;
   logic [31:0]   id_conf_wdata;
   logic          ic_txbusy;
   logic          ic_rxrdy;
   logic [7:0]    id_rxdw;
   logic          oc_txena;
   logic [7:0]    od_txdw;
   logic [31:0]   od_conf_rdata;
   logic          oc_done_wr;
   logic          oc_done_rd;
   logic          oc_busy;
   logic          oc_timeout;
   logic [2:0]    od_sleds;

   int            n_cmp;
   int            n_mis;

   // UART model / monitor state
   logic [7:0]    tx_q[$];
   int            n_txena;
   int            n_done_wr;
   int            n_done_rd;
   int            n_to;
   int            n_err_led;
   int            txena_cyc;
   int            to_cyc;
   int            busy_left;
   logic          uart_stuck;
   logic [31:0]   rd_at_done;
   int            cyc;

   bcom_conf_host_fsm #(
      .NBYTES        (NB),
      .CMD_WR        (8'hB1),
      .CMD_RD        (8'hB2),
      .TIMEOUT_CYC   (TO),
      .BUSY_WAIT_CYC (BWC)
   ) dut (
      .clk           (clk),
      .ic_rst        (ic_rst),
      .ic_start_wr   (ic_start_wr),
      .ic_start_rd   (ic_start_rd),
      .id_conf_wdata (id_conf_wdata),
      .ic_txbusy     (ic_txbusy),
      .ic_rxrdy      (ic_rxrdy),
      .id_rxdw       (id_rxdw),
      .oc_txena      (oc_txena),
      .od_txdw       (od_txdw),
      .od_conf_rdata (od_conf_rdata),
      .oc_done_wr    (oc_done_wr),
      .oc_done_rd    (oc_done_rd),
      .oc_busy       (oc_busy),
      .oc_timeout    (oc_timeout),
      .od_sleds      (od_sleds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // UART model and pulse monitor, sampling on the falling edge.
   initial begin
      ic_txbusy  = 1'b0;
      busy_left  = 0;
      n_txena    = 0;
      n_done_wr  = 0;
      n_done_rd  = 0;
      n_to       = 0;
      n_err_led  = 0;
      txena_cyc  = 0;
      to_cyc     = 0;
      rd_at_done = 32'h0;
      forever begin
         @(negedge clk);
         if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) ic_txbusy = 1'b0;
         end
         if (oc_txena === 1'b1) begin
            tx_q.push_back(od_txdw);
            n_txena   = n_txena + 1;
            txena_cyc = cyc;
            if (uart_stuck !== 1'b1) begin
               ic_txbusy = 1'b1;
               busy_left = 10;
            end
         end
         if (oc_done_wr === 1'b1) n_done_wr = n_done_wr + 1;
         if (oc_done_rd === 1'b1) begin
            n_done_rd  = n_done_rd + 1;
            rd_at_done = od_conf_rdata;
         end
         if (oc_timeout === 1'b1) begin
            n_to   = n_to + 1;
            to_cyc = cyc;
         end
         if (od_sleds === 3'b111) n_err_led = n_err_led + 1;
      end
   end

   // One-cycle start request; returns on the falling edge after it was sampled.
   task automatic pulse_start(input logic wr, input logic rd, input logic [31:0] data);
      @(negedge clk);
      ic_start_wr   = wr;
      ic_start_rd   = rd;
      id_conf_wdata = data;
      @(negedge clk);
      ic_start_wr   = 1'b0;
      ic_start_rd   = 1'b0;
   endtask

   // One reply byte; at_cyc is the cycle count when ic_rxrdy was raised.
   task automatic send_byte(input logic [7:0] b, output int at_cyc);
      ic_rxrdy = 1'b1;
      id_rxdw  = b;
      at_cyc   = cyc;
      @(negedge clk);
      ic_rxrdy = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k;
      k = 0;
      while (oc_busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (oc_busy !== 1'b0) begin
         n_mis++;
         $display("FAIL %s_idle: oc_busy=%b after %0d cycles, required 0", name, oc_busy, budget);
      end
      @(negedge clk);
   endtask

   task automatic wait_sleds(input logic [2:0] code, input int budget, input string name);
      int k;
      k = 0;
      while (od_sleds !== code && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (od_sleds !== code) begin
         n_mis++;
         $display("FAIL %s_reach: od_sleds=%b, required %b within %0d cycles", name, od_sleds, code, budget);
      end
   endtask

   task automatic test_reset();
      ic_rst = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({oc_txena, oc_done_wr, oc_done_rd, oc_busy, oc_timeout} !== 5'b0) begin
         n_mis++;
         $display("FAIL reset_ctl: got %b required 00000", {oc_txena, oc_done_wr, oc_done_rd, oc_busy, oc_timeout});
      end
      n_cmp++;
      if (od_txdw !== 8'h00 || od_conf_rdata !== 32'h0 || od_sleds !== 3'b000) begin
         n_mis++;
         $display("FAIL reset_data: txdw=%h rdata=%h sleds=%b required 00/00000000/000", od_txdw, od_conf_rdata, od_sleds);
      end
      ic_rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write();
      int base, wr0, rd0;
      logic [7:0] exp_b [5];
      exp_b = '{8'hB1, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      base = tx_q.size();
      wr0  = n_done_wr;
      rd0  = n_done_rd;
      pulse_start(1'b1, 1'b0, 32'hDEADBEEF);
      n_cmp++;
      if (od_sleds !== 3'b001 || oc_busy !== 1'b1) begin
         n_mis++;
         $display("FAIL wr_accept: sleds=%b busy=%b required 001/1", od_sleds, oc_busy);
      end
      wait_idle(400, "wr");
      n_cmp++;
      if (tx_q.size() - base !== 5) begin
         n_mis++;
         $display("FAIL wr_nbytes: got %0d required 5", tx_q.size() - base);
      end
      for (int i = 0; i < 5; i++) begin
         if (base + i < tx_q.size()) begin
            n_cmp++;
            if (tx_q[base + i] !== exp_b[i]) begin
               n_mis++;
               $display("FAIL wr_byte%0d: got %h required %h", i, tx_q[base + i], exp_b[i]);
            end
         end
      end
      n_cmp++;
      if (n_done_wr - wr0 !== 1 || n_done_rd - rd0 !== 0) begin
         n_mis++;
         $display("FAIL wr_done: done_wr=%0d done_rd=%0d required 1/0", n_done_wr - wr0, n_done_rd - rd0);
      end
   endtask

   task automatic test_read();
      int base, rd0, wr0, t;
      base = tx_q.size();
      rd0  = n_done_rd;
      wr0  = n_done_wr;
      pulse_start(1'b0, 1'b1, 32'h0);
      // Stray byte while still transmitting must be ignored.
      send_byte(8'hEE, t);
      wait_sleds(3'b101, 200, "rd");
      send_byte(8'h12, t);
      send_byte(8'h34, t);
      send_byte(8'h56, t);
      send_byte(8'h78, t);
      wait_idle(200, "rd");
      n_cmp++;
      if (tx_q.size() - base !== 1) begin
         n_mis++;
         $display("FAIL rd_nstrobe: got %0d required 1", tx_q.size() - base);
      end
      if (tx_q.size() > base) begin
         n_cmp++;
         if (tx_q[base] !== 8'hB2) begin
            n_mis++;
            $display("FAIL rd_cmd: got %h required b2", tx_q[base]);
         end
      end
      n_cmp++;
      if (n_done_rd - rd0 !== 1 || n_done_wr - wr0 !== 0) begin
         n_mis++;
         $display("FAIL rd_done: done_rd=%0d done_wr=%0d required 1/0", n_done_rd - rd0, n_done_wr - wr0);
      end
      n_cmp++;
      if (rd_at_done !== 32'h12345678) begin
         n_mis++;
         $display("FAIL rd_data_at_done: got %h required 12345678", rd_at_done);
      end
      n_cmp++;
      if (od_conf_rdata !== 32'h12345678) begin
         n_mis++;
         $display("FAIL rd_data_hold: got %h required 12345678", od_conf_rdata);
      end
   endtask

   task automatic test_read_timeout();
      int to0, rd0, r3, t;
      to0 = n_to;
      rd0 = n_done_rd;
      pulse_start(1'b0, 1'b1, 32'h0);
      wait_sleds(3'b101, 200, "rdto");
      send_byte(8'hAA, t);
      send_byte(8'hBB, t);
      send_byte(8'hCC, r3);
      wait_idle(200, "rdto");
      n_cmp++;
      if (n_to - to0 !== 1 || n_done_rd - rd0 !== 0) begin
         n_mis++;
         $display("FAIL rdto_pulse: timeouts=%0d done_rd=%0d required 1/0", n_to - to0, n_done_rd - rd0);
      end
      // Byte sampled at edge r3+1; TIMEOUT_CYC empty cycles follow it.
      n_cmp++;
      if (to_cyc !== r3 + 1 + TO) begin
         n_mis++;
         $display("FAIL rdto_time: timeout at cycle %0d required %0d", to_cyc, r3 + 1 + TO);
      end
      n_cmp++;
      if (od_conf_rdata !== 32'h12345678) begin
         n_mis++;
         $display("FAIL rdto_keep: got %h required 12345678", od_conf_rdata);
      end
      // The next read is accepted and completes normally.
      rd0 = n_done_rd;
      pulse_start(1'b0, 1'b1, 32'h0);
      n_cmp++;
      if (od_sleds !== 3'b001 || oc_busy !== 1'b1) begin
         n_mis++;
         $display("FAIL rdto_next_accept: sleds=%b busy=%b required 001/1", od_sleds, oc_busy);
      end
      wait_sleds(3'b101, 200, "rdto_next");
      send_byte(8'h9A, t);
      send_byte(8'hBC, t);
      send_byte(8'hDE, t);
      send_byte(8'hF0, t);
      wait_idle(200, "rdto_next");
      n_cmp++;
      if (n_done_rd - rd0 !== 1 || od_conf_rdata !== 32'h9ABCDEF0) begin
         n_mis++;
         $display("FAIL rdto_next_data: done_rd=%0d rdata=%h required 1/9abcdef0", n_done_rd - rd0, od_conf_rdata);
      end
   endtask

   task automatic test_busy_stuck();
      int base, to0, led0, wr0;
      uart_stuck = 1'b1;
      base = tx_q.size();
      to0  = n_to;
      led0 = n_err_led;
      wr0  = n_done_wr;
      pulse_start(1'b1, 1'b0, 32'h0F0F0F0F);
      wait_idle(200, "stuck");
      n_cmp++;
      if (tx_q.size() - base !== 1) begin
         n_mis++;
         $display("FAIL stuck_nstrobe: got %0d required 1", tx_q.size() - base);
      end
      n_cmp++;
      if (n_to - to0 !== 1 || n_done_wr - wr0 !== 0) begin
         n_mis++;
         $display("FAIL stuck_pulse: timeouts=%0d done_wr=%0d required 1/0", n_to - to0, n_done_wr - wr0);
      end
      // Strobe cycle, then BUSY_WAIT_CYC cycles in TX_WH, then ERR.
      n_cmp++;
      if (to_cyc - txena_cyc !== 1 + BWC) begin
         n_mis++;
         $display("FAIL stuck_time: timeout %0d cycles after strobe, required %0d", to_cyc - txena_cyc, 1 + BWC);
      end
      n_cmp++;
      if (n_err_led - led0 !== 1) begin
         n_mis++;
         $display("FAIL stuck_led: sleds=111 for %0d cycles, required 1", n_err_led - led0);
      end
      uart_stuck = 1'b0;
   endtask

   task automatic test_start_collision();
      int base, wr0, rd0;
      logic [7:0] exp_b [5];
      exp_b = '{8'hB1, 8'hCA, 8'hFE, 8'h01, 8'h23};
      base = tx_q.size();
      wr0  = n_done_wr;
      rd0  = n_done_rd;
      pulse_start(1'b1, 1'b1, 32'hCAFE0123);
      wait_sleds(3'b011, 100, "coll");
      pulse_start(1'b0, 1'b1, 32'h0);
      wait_idle(400, "coll");
      n_cmp++;
      if (tx_q.size() - base !== 5) begin
         n_mis++;
         $display("FAIL coll_nbytes: got %0d required 5", tx_q.size() - base);
      end
      for (int i = 0; i < 5; i++) begin
         if (base + i < tx_q.size()) begin
            n_cmp++;
            if (tx_q[base + i] !== exp_b[i]) begin
               n_mis++;
               $display("FAIL coll_byte%0d: got %h required %h", i, tx_q[base + i], exp_b[i]);
            end
         end
      end
      repeat (20) @(negedge clk);
      n_cmp++;
      if (oc_busy !== 1'b0 || tx_q.size() - base !== 5) begin
         n_mis++;
         $display("FAIL coll_dropped: busy=%b strobes=%0d required 0/5", oc_busy, tx_q.size() - base);
      end
      n_cmp++;
      if (n_done_wr - wr0 !== 1 || n_done_rd - rd0 !== 0) begin
         n_mis++;
         $display("FAIL coll_done: done_wr=%0d done_rd=%0d required 1/0", n_done_wr - wr0, n_done_rd - rd0);
      end
   endtask

   task automatic test_reset_midwrite();
      int base, wr0, k;
      logic [7:0] exp_b [5];
      exp_b = '{8'hB1, 8'h55, 8'h66, 8'h77, 8'h88};
      base = n_txena;
      pulse_start(1'b1, 1'b0, 32'h11223344);
      k = 0;
      while (n_txena - base < 3 && k < 200) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (n_txena - base < 3) begin
         n_mis++;
         $display("FAIL rstmid_reach: strobes=%0d required 3", n_txena - base);
      end
      ic_rst = 1'b1;
      @(negedge clk);
      ic_rst = 1'b0;
      n_cmp++;
      if ({oc_txena, oc_done_wr, oc_done_rd, oc_busy, oc_timeout} !== 5'b0 || od_sleds !== 3'b000) begin
         n_mis++;
         $display("FAIL rstmid_ctl: ctl=%b sleds=%b required 00000/000", {oc_txena, oc_done_wr, oc_done_rd, oc_busy, oc_timeout}, od_sleds);
      end
      n_cmp++;
      if (od_txdw !== 8'h00 || od_conf_rdata !== 32'h0) begin
         n_mis++;
         $display("FAIL rstmid_data: txdw=%h rdata=%h required 00/00000000", od_txdw, od_conf_rdata);
      end
      base = tx_q.size();
      wr0  = n_done_wr;
      pulse_start(1'b1, 1'b0, 32'h55667788);
      wait_idle(400, "rstmid");
      n_cmp++;
      if (tx_q.size() - base !== 5) begin
         n_mis++;
         $display("FAIL rstmid_nbytes: got %0d required 5", tx_q.size() - base);
      end
      for (int i = 0; i < 5; i++) begin
         if (base + i < tx_q.size()) begin
            n_cmp++;
            if (tx_q[base + i] !== exp_b[i]) begin
               n_mis++;
               $display("FAIL rstmid_byte%0d: got %h required %h", i, tx_q[base + i], exp_b[i]);
            end
         end
      end
      n_cmp++;
      if (n_done_wr - wr0 !== 1) begin
         n_mis++;
         $display("FAIL rstmid_done: got %0d required 1", n_done_wr - wr0);
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_mis         = 0;
      ic_rst        = 1'b1;
      ic_start_wr   = 1'b0;
      ic_start_rd   = 1'b0;
      id_conf_wdata = 32'h0;
      ic_rxrdy      = 1'b0;
      id_rxdw       = 8'h00;
      uart_stuck    = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_read_timeout();
      test_busy_stuck();
      test_start_collision();
      test_reset_midwrite();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
